// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access sequencer.
// Trap sequence length depends on the CSR_TRAP_TVAL_EN build macro.
package csr_pkg;

    typedef logic [11:0] csr_addr_t;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_mode_t;

    typedef enum logic [2:0] {
        CSR_F3_RW  = 3'b001,
        CSR_F3_RS  = 3'b010,
        CSR_F3_RC  = 3'b011,
        CSR_F3_RWI = 3'b101,
        CSR_F3_RSI = 3'b110,
        CSR_F3_RCI = 3'b111
    } csr_funct3_t;

    typedef enum logic [1:0] {
        CSR_WRITE_NONE,
        CSR_WRITE_RW,
        CSR_WRITE_RS,
        CSR_WRITE_RC
    } csr_write_func;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        WR,
        RESP,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STRD,
        T_STWR,
        T_VEC,
        T_DONE
    } csr_ctrl_state_t;

    localparam csr_addr_t CSR_ADDR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_ADDR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_ADDR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_ADDR_MCAUSE  = 12'h342;
    localparam csr_addr_t CSR_ADDR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Immediate forms share the register-form operation
    function automatic csr_write_func csr_write_func_of(input logic [2:0] f3);
        case (f3)
            CSR_F3_RW, CSR_F3_RWI: return CSR_WRITE_RW;
            CSR_F3_RS, CSR_F3_RSI: return CSR_WRITE_RS;
            CSR_F3_RC, CSR_F3_RCI: return CSR_WRITE_RC;
            default:               return CSR_WRITE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/csr_access_check.sv
// Combinational legality and read/write decode for a CSR instruction.
// Part of csr_access_ctrl (optional macro CSR_TRAP_TVAL_EN is not used here).
module csr_access_check
    import csr_pkg::*;
(
    input  logic [3:0]    addr_hi_i,
    input  logic [2:0]    funct3_i,
    input  logic [1:0]    priv_i,
    input  logic          rd_x0_i,
    input  logic          src_x0_i,
    input  logic          exists_i,
    output csr_write_func wfunc_o,
    output logic          do_read_o,
    output logic          do_write_o,
    output logic          illegal_o
);

    csr_write_func wf;

    always_comb begin
        wf         = csr_write_func_of(funct3_i);
        do_read_o  = 1'b0;
        do_write_o = 1'b0;
        unique case (1'b1)
            (wf == CSR_WRITE_RW): begin
                do_write_o = 1'b1;
                do_read_o  = !rd_x0_i;
            end
            (wf == CSR_WRITE_RS),
            (wf == CSR_WRITE_RC): begin
                do_write_o = !src_x0_i;
                do_read_o  = 1'b1;
            end
            default: ;
        endcase
        // addr[9:8] is the lowest privilege, addr[11:10]==11 is read-only
        illegal_o = !exists_i
                 || (addr_hi_i[1:0] > priv_i)
                 || ((addr_hi_i[3:2] == 2'b11) && do_write_o)
                 || (wf == CSR_WRITE_NONE);
        wfunc_o   = wf;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequencer/arbiter for the single-port CSR file: CSR read-modify-write and trap entry.
// Build macro CSR_TRAP_TVAL_EN adds the mtval write to the trap sequence.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int VECTORED_MTVEC = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      priv_mode,
    input  logic            csr_req_valid,
    output logic            csr_req_ready,
    input  logic [11:0]     csr_req_addr,
    input  logic [2:0]      csr_req_funct3,
    input  logic [XLEN-1:0] csr_req_src,
    input  logic            csr_req_rd_x0,
    input  logic            csr_req_src_x0,
    output logic            csr_resp_valid,
    input  logic            csr_resp_ready,
    output logic [XLEN-1:0] csr_resp_rdata,
    output logic            csr_resp_illegal,
    input  logic            trap_req_valid,
    output logic            trap_req_ready,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    output logic            trap_done,
    output logic [XLEN-1:0] trap_target,
    output logic            csr_rd_en,
    output logic            csr_wr_en,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_exists
);

    csr_ctrl_state_t state_q;
    logic            rd_en_q, wr_en_q;
    csr_addr_t       addr_q, req_addr_q;
    logic [XLEN-1:0] wdata_q, src_q, rdata_q;
    logic [XLEN-1:0] cause_q, target_q;
    logic            resp_valid_q, illegal_q, done_q, do_write_q;
    csr_write_func   wfunc_q;
    logic [1:0]      priv_q;

    csr_write_func   chk_wfunc;
    logic            chk_read, chk_write, chk_illegal;
    logic [XLEN-1:0] rmw_wdata_d, mstatus_d, target_d;
    logic            unused_bits;

`ifdef CSR_TRAP_TVAL_EN
    logic [XLEN-1:0] tval_q;
    assign unused_bits = ^trap_epc[1:0];
`else
    assign unused_bits = ^{trap_epc[1:0], trap_tval};
`endif

    csr_access_check u_check (
        .addr_hi_i  (csr_req_addr[11:8]),
        .funct3_i   (csr_req_funct3),
        .priv_i     (priv_mode),
        .rd_x0_i    (csr_req_rd_x0),
        .src_x0_i   (csr_req_src_x0),
        .exists_i   (csr_exists),
        .wfunc_o    (chk_wfunc),
        .do_read_o  (chk_read),
        .do_write_o (chk_write),
        .illegal_o  (chk_illegal)
    );

    assign trap_req_ready   = (state_q == IDLE) && !reset;
    assign csr_req_ready    = trap_req_ready && !trap_req_valid;
    assign csr_resp_valid   = resp_valid_q;
    assign csr_resp_rdata   = rdata_q;
    assign csr_resp_illegal = illegal_q;
    assign trap_done        = done_q;
    assign trap_target      = target_q;
    assign csr_rd_en        = rd_en_q;
    assign csr_wr_en        = wr_en_q;
    assign csr_addr         = addr_q;
    assign csr_wdata        = wdata_q;

    always_comb begin
        unique case (wfunc_q)
            CSR_WRITE_RS: rmw_wdata_d = csr_rdata | src_q;
            CSR_WRITE_RC: rmw_wdata_d = csr_rdata & ~src_q;
            default:      rmw_wdata_d = src_q;
        endcase
        mstatus_d = csr_rdata;
        mstatus_d[MSTATUS_MPIE] = csr_rdata[MSTATUS_MIE];
        mstatus_d[MSTATUS_MIE]  = 1'b0;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
        target_d = {csr_rdata[XLEN-1:2], 2'b00};
        if ((VECTORED_MTVEC != 0) && (csr_rdata[1:0] == 2'b01) && cause_q[XLEN-1])
            target_d = target_d + {cause_q[XLEN-3:0], 2'b00};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_addr_q   <= '0;
            src_q        <= '0;
            rdata_q      <= '0;
            cause_q      <= '0;
            target_q     <= '0;
            resp_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            done_q       <= 1'b0;
            do_write_q   <= 1'b0;
            wfunc_q      <= CSR_WRITE_NONE;
            priv_q       <= '0;
`ifdef CSR_TRAP_TVAL_EN
            tval_q       <= '0;
`endif
        end else begin
            // Strobes are single-cycle; bus fields idle at zero
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trap_req_valid) begin
                        cause_q <= trap_cause;
                        priv_q  <= priv_mode;
`ifdef CSR_TRAP_TVAL_EN
                        tval_q  <= trap_tval;
`endif
                        wr_en_q <= 1'b1;
                        addr_q  <= CSR_ADDR_MEPC;
                        wdata_q <= {trap_epc[XLEN-1:2], 2'b00};
                        state_q <= T_EPC;
                    end else if (csr_req_valid) begin
                        req_addr_q <= csr_req_addr;
                        src_q      <= csr_req_src;
                        wfunc_q    <= chk_wfunc;
                        do_write_q <= chk_write;
                        rdata_q    <= '0;
                        illegal_q  <= chk_illegal;
                        if (chk_illegal) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (chk_read) begin
                            rd_en_q <= 1'b1;
                            addr_q  <= csr_req_addr;
                            state_q <= RD;
                        end else begin
                            wr_en_q <= 1'b1;
                            addr_q  <= csr_req_addr;
                            wdata_q <= csr_req_src;
                            state_q <= WR;
                        end
                    end
                end
                RD: begin
                    rdata_q <= csr_rdata;
                    if (do_write_q) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= req_addr_q;
                        wdata_q <= rmw_wdata_d;
                        state_q <= WR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (csr_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        illegal_q    <= 1'b0;
                        rdata_q      <= '0;
                        state_q      <= IDLE;
                    end
                end
                T_EPC: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= CSR_ADDR_MCAUSE;
                    wdata_q <= cause_q;
                    state_q <= T_CAUSE;
                end
                T_CAUSE: begin
`ifdef CSR_TRAP_TVAL_EN
                    wr_en_q <= 1'b1;
                    addr_q  <= CSR_ADDR_MTVAL;
                    wdata_q <= tval_q;
                    state_q <= T_TVAL;
`else
                    rd_en_q <= 1'b1;
                    addr_q  <= CSR_ADDR_MSTATUS;
                    state_q <= T_STRD;
`endif
                end
                T_TVAL: begin
                    rd_en_q <= 1'b1;
                    addr_q  <= CSR_ADDR_MSTATUS;
                    state_q <= T_STRD;
                end
                T_STRD: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= CSR_ADDR_MSTATUS;
                    wdata_q <= mstatus_d;
                    state_q <= T_STWR;
                end
                T_STWR: begin
                    rd_en_q <= 1'b1;
                    addr_q  <= CSR_ADDR_MTVEC;
                    state_q <= T_VEC;
                end
                T_VEC: begin
                    target_q <= target_d;
                    done_q   <= 1'b1;
                    state_q  <= T_DONE;
                end
                T_DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
